// File: rtl/bcom_pkg.sv
// Shared constants, FSM state encoding and frame layout for the byte-command host.
//   CMD_WR / CMD_RD : command bytes that open a write / read frame
//   N_DATA          : data bytes carried by every frame
//   bcom_frame_t    : 88-bit payload, frec_mod in the low bits so that byte 1
//                     of the frame is bits [7:0] and the payload shifts out LSB first
package bcom_pkg;

    localparam logic [7:0]  CMD_WR  = 8'h0F;
    localparam logic [7:0]  CMD_RD  = 8'hF0;
    localparam int unsigned N_DATA  = 11;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FRAME_W = 88;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_LOAD,
        S_TX_GUARD,
        S_TX_WAIT,
        S_RX_WAIT,
        S_DONE
    } state_t;

    // Field offsets: frec_mod 0, frec_por 24, im_am 48, im_fm 64, control 80
    typedef struct packed {
        logic [7:0]  control;
        logic [15:0] im_fm;
        logic [15:0] im_am;
        logic [23:0] frec_por;
        logic [23:0] frec_mod;
    } bcom_frame_t;

endpackage

// File: rtl/bcom_host.sv
// Host-side initiator for the byte-command configuration protocol.
// Sends write frames (0x0F + 11 data bytes) or read frames (0xF0) through a
// UART TX byte interface and collects the 11 read-back bytes from UART RX.
// Ports:
//   clk, ic_rst_n                 clock, async active-low reset
//   ic_wr_req / ic_rd_req         frame requests, sampled only when idle
//   id_frec_mod .. id_control     values to write, snapshot on acceptance
//   ic_txbusy, od_txdw, oc_txena  UART TX byte handshake
//   id_rxdw, ic_rxrdy             UART RX byte + strobe (rising edge counts)
//   od_rd_*                       read-back registers, updated on complete reads
//   oc_busy, oc_done, oc_timeout  status: frame active, done pulse, read abort pulse
module bcom_host
    import bcom_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 100000,
    parameter int unsigned TO_W         = 17
) (
    input  logic        clk,
    input  logic        ic_rst_n,
    input  logic        ic_wr_req,
    input  logic        ic_rd_req,
    input  logic [23:0] id_frec_mod,
    input  logic [23:0] id_frec_por,
    input  logic [15:0] id_im_am,
    input  logic [15:0] id_im_fm,
    input  logic [7:0]  id_control,
    input  logic        ic_txbusy,
    output logic [7:0]  od_txdw,
    output logic        oc_txena,
    input  logic [7:0]  id_rxdw,
    input  logic        ic_rxrdy,
    output logic [23:0] od_rd_frec_mod,
    output logic [23:0] od_rd_frec_por,
    output logic [15:0] od_rd_im_am,
    output logic [15:0] od_rd_im_fm,
    output logic [7:0]  od_rd_control,
    output logic        oc_busy,
    output logic        oc_done,
    output logic        oc_timeout
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    bcom_frame_t       sr_q, sr_d;
    bcom_frame_t       shadow_q, shadow_d;
    bcom_frame_t       rdback_q, rdback_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [7:0]        txdw_q, txdw_d;
    logic              txena_q, txena_d;
    logic              timeout_q, timeout_d;
    logic              done_q, busy_q;
    logic              rx_prev_q;
    logic              rx_edge_c;
    bcom_frame_t       snap_c;

    assign snap_c = '{control:  id_control,
                      im_fm:    id_im_fm,
                      im_am:    id_im_am,
                      frec_por: id_frec_por,
                      frec_mod: id_frec_mod};

    // A held strobe counts once: only the 0->1 transition captures a byte
    assign rx_edge_c = ic_rxrdy & ~rx_prev_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            sr_q      <= '0;
            shadow_q  <= '0;
            rdback_q  <= '0;
            to_q      <= '0;
            txdw_q    <= '0;
            txena_q   <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            sr_q      <= sr_d;
            shadow_q  <= shadow_d;
            rdback_q  <= rdback_d;
            to_q      <= to_d;
            txdw_q    <= txdw_d;
            txena_q   <= txena_d;
            timeout_q <= timeout_d;
            done_q    <= (state_d == S_DONE);
            busy_q    <= (state_d != S_IDLE);
            rx_prev_q <= ic_rxrdy;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        sr_d      = sr_q;
        shadow_d  = shadow_q;
        rdback_d  = rdback_q;
        to_d      = to_q;
        txdw_d    = txdw_q;
        txena_d   = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ic_wr_req) begin
                    rd_d    = 1'b0;
                    txdw_d  = CMD_WR;
                    sr_d    = snap_c;
                    state_d = S_TX_LOAD;
                end else if (ic_rd_req) begin
                    rd_d    = 1'b1;
                    txdw_d  = CMD_RD;
                    sr_d    = snap_c;
                    state_d = S_TX_LOAD;
                end
            end

            S_TX_LOAD: begin
                if (!ic_txbusy) begin
                    txena_d = 1'b1;
                    state_d = S_TX_GUARD;
                end
            end

            // Busy is ignored here so a UART that raises busy late is not missed
            S_TX_GUARD: begin
                state_d = S_TX_WAIT;
            end

            S_TX_WAIT: begin
                if (!ic_txbusy) begin
                    if (rd_q) begin
                        cnt_d   = '0;
                        to_d    = '0;
                        state_d = S_RX_WAIT;
                    end else if (cnt_q < CNT_W'(N_DATA)) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        txdw_d  = sr_q[7:0];
                        sr_d    = bcom_frame_t'(sr_q >> 8);
                        state_d = S_TX_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            // Bytes shift in from the top so byte 1 lands in bits [7:0]
            S_RX_WAIT: begin
                if (cnt_q == CNT_W'(N_DATA)) begin
                    rdback_d = shadow_q;
                    state_d  = S_DONE;
                end else if (rx_edge_c) begin
                    shadow_d = bcom_frame_t'({id_rxdw, shadow_q[FRAME_W-1:8]});
                    cnt_d    = cnt_q + CNT_W'(1);
                    to_d     = '0;
                end else if (to_q == TO_W'(TIMEOUT_CLKS - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign od_txdw        = txdw_q;
    assign oc_txena       = txena_q;
    assign oc_busy        = busy_q;
    assign oc_done        = done_q;
    assign oc_timeout     = timeout_q;
    assign od_rd_frec_mod = rdback_q.frec_mod;
    assign od_rd_frec_por = rdback_q.frec_por;
    assign od_rd_im_am    = rdback_q.im_am;
    assign od_rd_im_fm    = rdback_q.im_fm;
    assign od_rd_control  = rdback_q.control;

endmodule

// File: doc/bcom_host.md
Name: bcom_host

Overview:
- Host-side initiator for the byte-command configuration protocol.
- Builds write frames from parallel register values and sends them through a UART TX byte interface. A write frame is the command byte 0x0F followed by 11 data bytes.
- Issues read frames (command byte 0xF0) and collects the 11 returned bytes from a UART RX byte interface into read-back registers.
- Sits between the system controller/test logic and the UART pair that links to the remote configuration responder.

Parameters:
TIMEOUT_CLKS, 100000, clock cycles allowed between consecutive RX bytes during a read before the read is aborted
TO_W, 17, width of the timeout counter (must hold TIMEOUT_CLKS)

Ports:
clk  in  1  system clock, rising edge
ic_rst_n  in  1  asynchronous active-low reset
ic_wr_req  in  1  request a write frame (sampled in IDLE only)
ic_rd_req  in  1  request a read frame (sampled in IDLE only)
id_frec_mod  in  24  value to write
id_frec_por  in  24  value to write
id_im_am  in  16  value to write
id_im_fm  in  16  value to write
id_control  in  8  value to write
ic_txbusy  in  1  UART TX busy
od_txdw  out  8  byte to transmit
oc_txena  out  1  one-cycle transmit strobe
id_rxdw  in  8  received byte
ic_rxrdy  in  1  received-byte strobe
od_rd_frec_mod  out  24  read-back value
od_rd_frec_por  out  24  read-back value
od_rd_im_am  out  16  read-back value
od_rd_im_fm  out  16  read-back value
od_rd_control  out  8  read-back value
oc_busy  out  1  frame in progress
oc_done  out  1  one-cycle pulse: frame completed
oc_timeout  out  1  one-cycle pulse: read aborted

Behaviour:
- Reset: one clock (clk); reset ic_rst_n is asynchronous, active-low. While asserted, all outputs are 0, the FSM is in IDLE and all counters are 0. Reset mid-frame abandons the frame immediately, and oc_txena drops in the same instant.
- Data byte order (index 1..11): frec_mod[7:0], [15:8], [23:16]; frec_por[7:0], [15:8], [23:16]; im_am[7:0], [15:8]; im_fm[7:0], [15:8]; control. The same order applies to TX and RX.
- Request sampling in IDLE:
  - ic_wr_req takes priority over ic_rd_req when both are high.
  - Requests outside IDLE are ignored.
  - All id_* inputs are snapshot into a 88-bit shift/hold register on acceptance, so later input changes do not affect the frame.
- FSM states:
  - IDLE: oc_busy=0. On an accepted request, load the command byte and go to TX_LOAD. Byte counter = 0.
  - TX_LOAD: wait until ic_txbusy=0. In that cycle drive oc_txena=1 for exactly one cycle with od_txdw valid. Go to TX_GUARD.
  - TX_GUARD: one cycle. ic_txbusy is ignored here, which covers UARTs that raise busy one cycle after the strobe. Go to TX_WAIT.
  - TX_WAIT: wait until ic_txbusy=0, then:
    - write frame with counter<11: increment the counter, present the next byte, go to TX_LOAD;
    - write frame with counter=11: go to DONE;
    - read frame: go to RX_WAIT with the counter cleared.
  - RX_WAIT:
    - Capture id_rxdw on each rising edge of ic_rxrdy (ic_rxrdy=1 and the previous sample 0). A strobe held for several cycles counts once.
    - Bytes go into a shadow register and the counter increments.
    - When the 11th byte is captured, commit the shadow register to the od_rd_* outputs in the next cycle and go to DONE.
    - The timeout counter clears on entry and on each captured byte. When it reaches TIMEOUT_CLKS: pulse oc_timeout, leave od_rd_* unchanged, go to IDLE.
  - DONE: oc_done=1 for one cycle, then IDLE.
- oc_busy=1 in every state except IDLE.
- Latency: a request accepted at edge N gives oc_txena at edge N+1, provided ic_txbusy=0.
- oc_txena is never asserted while ic_txbusy=1. od_txdw holds its value from the strobe until the next byte is loaded.
- ic_rxrdy strobes outside RX_WAIT are discarded.

Decomposition:
- Package bcom_pkg:
  - CMD_WR=8'h0F, CMD_RD=8'hF0, N_DATA=11;
  - FSM state enum (IDLE, TX_LOAD, TX_GUARD, TX_WAIT, RX_WAIT, DONE);
  - frame field offsets.
- Optional sub-module bcom_tx_hs: single-byte TX handshake covering TX_LOAD/TX_GUARD/TX_WAIT, with a start/ack interface.

Test Plan:
1. Write frame: after reset, ic_wr_req with frec_mod=030201, frec_por=060504, im_am=0807, im_fm=0A09, control=0B; busy model holds ic_txbusy for 11 cycles per byte. Required response:
   - od_txdw sequence 0F,01..0B;
   - 12 oc_txena pulses, none while busy;
   - exactly one oc_done.
2. Read frame: ic_rd_req; the responder model returns bytes 01..0B with 20-30 clk gaps. Required response:
   - od_txdw=F0 strobed once;
   - od_rd_frec_mod=030201, od_rd_frec_por=060504, od_rd_im_am=0807, od_rd_im_fm=0A09, od_rd_control=0B;
   - oc_done pulse after the 11th byte.
3. Read timeout with TIMEOUT_CLKS=200: only 5 bytes returned. Required response:
   - oc_timeout pulses 200 clk after the 5th byte;
   - od_rd_* keep their previous values;
   - oc_busy=0 and no oc_done.
4. Request arbitration:
   - ic_wr_req and ic_rd_req in the same cycle → write frame only.
   - ic_rd_req pulsed mid-write → ignored; still 12 strobes total.
5. Reset mid-frame: ic_rst_n low after the 4th TX byte. Required response:
   - outputs go to 0 immediately;
   - a following ic_wr_req restarts at byte 0F.
6. Handshake edges:
   - ic_txbusy=1 at request → oc_txena withheld until busy=0.
   - ic_rxrdy held 3 cycles → one byte counted.
